// File: rtl/icache_pkg.sv
// Line geometry and FSM encoding shared by the icache miss path and its refill responder.
package icache_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 4;
    localparam int WORD_BYTES     = 4;
    localparam int WORD_W         = 8 * WORD_BYTES;
    localparam int LINE_W         = 8 * LINE_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } refill_state_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/icache_refill_responder.sv
// Fetches one 16-byte line as four sequential word reads from a fixed-latency memory
// and returns the assembled line over a valid/ready response channel.
//
//   state | meaning
//   IDLE  | no request held; ready for a new line
//   READ  | single-cycle read strobe for word word_idx
//   WAIT  | counting down MEM_LAT cycles until the word arrives
//   RESP  | full line presented, waiting for resp_ready
module icache_refill_responder
    import icache_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [LINE_W-1:0] resp_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WORD_W-1:0] mem_rd_data
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    refill_state_t     state;
    refill_state_t     state_nxt;
    logic [ADDR_W-1:0] line_addr;
    logic [1:0]        word_idx;
    logic [3:0]        lat_cnt;
    line_t             line_q;
    logic              hs;
    logic              beat_done;
    logic [ADDR_W-1:0] word_addr;

    // Offset bits are dropped on purpose; the line is always fetched from its base.
    logic unused_offset;
    assign unused_offset = &{1'b0, req_addr[OFFSET_W-1:0]};

    assign hs        = req_valid && req_ready;
    assign beat_done = (state == WAIT) && (lat_cnt == 4'd1);
    // line_addr has a zero offset, so adding at most 12 never carries out of the line.
    assign word_addr = line_addr + ADDR_W'({word_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs) state_nxt = READ;
            READ: state_nxt = WAIT;
            WAIT: begin
                if (beat_done) state_nxt = (word_idx == 2'd3) ? RESP : READ;
            end
            RESP: begin
                if (resp_ready) state_nxt = hs ? READ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE) || ((state == RESP) && resp_ready);
        resp_valid  = (state == RESP);
        resp_addr   = (state == RESP) ? line_addr : '0;
        resp_data   = line_q;
        mem_rd_en   = (state == READ);
        mem_rd_addr = (state == READ) ? word_addr : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_addr <= '0;
            word_idx  <= '0;
            lat_cnt   <= '0;
            line_q    <= '0;
        end else if (hs) begin
            line_addr <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            word_idx  <= '0;
        end else begin
            case (state)
                READ: lat_cnt <= LAT_INIT;
                WAIT: begin
                    if (beat_done) begin
                        line_q[{word_idx, 5'b0} +: WORD_W] <= mem_rd_data;
                        lat_cnt                            <= '0;
                        if (word_idx != 2'd3) word_idx <= word_idx + 2'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench: one responder at MEM_LAT=1 and one at MEM_LAT=3, each with a small memory model.
module tb_icache_refill_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // MEM_LAT=1 instance
    logic         req_valid1, req_ready1, resp_valid1, resp_ready1, mem_rd_en1;
    logic [63:0]  req_addr1, resp_addr1, mem_rd_addr1;
    logic [127:0] resp_data1;
    logic [31:0]  mem_rd_data1;
    logic [63:0]  pipe1;

    // MEM_LAT=3 instance
    logic         req_valid3, req_ready3, resp_valid3, resp_ready3, mem_rd_en3;
    logic [63:0]  req_addr3, resp_addr3, mem_rd_addr3;
    logic [127:0] resp_data3;
    logic [31:0]  mem_rd_data3;
    logic [63:0]  pipe3 [3];

    icache_refill_responder #(.ADDR_W(64), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_addr(resp_addr1),
        .resp_data(resp_data1),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1)
    );

    icache_refill_responder #(.ADDR_W(64), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_addr(resp_addr3),
        .resp_data(resp_data3),
        .mem_rd_en(mem_rd_en3), .mem_rd_addr(mem_rd_addr3), .mem_rd_data(mem_rd_data3)
    );

    // Memory returns {C0DE, addr[15:0]}; idle cycles return a 0BAD marker.
    always @(posedge clk) begin
        pipe1    <= mem_rd_en1 ? mem_rd_addr1 : 64'h0BAD;
        pipe3[0] <= mem_rd_en3 ? mem_rd_addr3 : 64'h0BAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rd_data1 = {16'hC0DE, pipe1[15:0]};
    assign mem_rd_data3 = {16'hC0DE, pipe3[2][15:0]};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [63:0] la);
        logic [63:0] a0, a1, a2, a3;
        a0 = la; a1 = la + 64'd4; a2 = la + 64'd8; a3 = la + 64'd12;
        return {16'hC0DE, a3[15:0], 16'hC0DE, a2[15:0], 16'hC0DE, a1[15:0], 16'hC0DE, a0[15:0]};
    endfunction

    // Called at a negedge with DUT1 able to accept; returns at the negedge where the line is shown.
    task automatic refill1(input logic [63:0] a, input string tag);
        logic [63:0] la;
        logic        exp_en;
        la = {a[63:4], 4'h0};
        req_valid1 = 1'b1;
        req_addr1  = a;
        #1;
        chk({tag, "_req_ready"}, 128'(req_ready1), 128'(1'b1));
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid1  = 1'b0;
                resp_ready1 = 1'b0;
                req_addr1   = 64'hDEAD_BEEF_DEAD_BEE0;
            end
            exp_en = (i == 1) || (i == 3) || (i == 5) || (i == 7);
            chk($sformatf("%s_rd_en_%0d", tag, i), 128'(mem_rd_en1), 128'(exp_en));
            if (exp_en)
                chk($sformatf("%s_rd_addr_%0d", tag, i), 128'(mem_rd_addr1),
                    128'(la + 64'(4 * ((i - 1) / 2))));
            chk($sformatf("%s_resp_valid_%0d", tag, i), 128'(resp_valid1), 128'(i == 9));
        end
        chk({tag, "_resp_addr"}, 128'(resp_addr1), 128'(la));
        chk({tag, "_resp_data"}, resp_data1, exp_line(la));
    endtask

    task automatic accept1(input string tag);
        resp_ready1 = 1'b1;
        @(negedge clk);
        resp_ready1 = 1'b0;
        #1;
        chk({tag, "_idle_valid"}, 128'(resp_valid1), 128'(1'b0));
        chk({tag, "_idle_ready"}, 128'(req_ready1), 128'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [63:0] hold_addr;
        logic [127:0] hold_data;
        logic exp_en;

        rst = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0; resp_ready1 = 1'b0;
        req_valid3 = 1'b0; req_addr3 = '0; resp_ready3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready1",   128'(req_ready1),   128'(1'b1));
        chk("rst_resp_valid1",  128'(resp_valid1),  128'(1'b0));
        chk("rst_mem_rd_en1",   128'(mem_rd_en1),   128'(1'b0));
        chk("rst_resp_addr1",   128'(resp_addr1),   128'(0));
        chk("rst_resp_data1",   resp_data1,         128'(0));
        chk("rst_mem_rd_addr1", 128'(mem_rd_addr1), 128'(0));
        chk("rst_req_ready3",   128'(req_ready3),   128'(1'b1));
        chk("rst_resp_valid3",  128'(resp_valid3),  128'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        // basic refill with offset bits set
        refill1(64'h0000_0000_8000_0004, "basic");
        chk("basic_data_const", resp_data1, 128'hC0DE000C_C0DE0008_C0DE0004_C0DE0000);

        // backpressure for 5 cycles
        hold_addr = resp_addr1;
        hold_data = resp_data1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), 128'(resp_valid1), 128'(1'b1));
            chk($sformatf("bp_addr_%0d", i),  128'(resp_addr1),  128'(hold_addr));
            chk($sformatf("bp_data_%0d", i),  resp_data1,        hold_data);
            chk($sformatf("bp_ready_%0d", i), 128'(req_ready1),  128'(1'b0));
            chk($sformatf("bp_rd_en_%0d", i), 128'(mem_rd_en1),  128'(1'b0));
        end
        accept1("bp");

        // back-to-back: second request accepted in the same cycle the first line is taken
        refill1(64'h0000_0000_0000_0040, "b2b_a");
        resp_ready1 = 1'b1;
        refill1(64'h0000_0000_0000_2010, "b2b_b");
        accept1("b2b");

        // reset during WAIT of word 2
        req_valid1 = 1'b1;
        req_addr1  = 64'h5000;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            req_valid1 = 1'b0;
            exp_en = (i == 1) || (i == 3) || (i == 5);
            chk($sformatf("mid_rd_en_%0d", i), 128'(mem_rd_en1), 128'(exp_en));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready",  128'(req_ready1),  128'(1'b1));
        chk("mid_rst_valid",  128'(resp_valid1), 128'(1'b0));
        chk("mid_rst_rd_en",  128'(mem_rd_en1),  128'(1'b0));
        chk("mid_rst_data",   resp_data1,        128'(0));
        refill1(64'h0000_0000_0000_3000, "after_rst");
        accept1("after_rst");

        // top-of-address-space line, no wrap
        refill1(64'hFFFF_FFFF_FFFF_FFFC, "wrap");
        accept1("wrap");

        // MEM_LAT=3 timing
        req_valid3 = 1'b1;
        req_addr3  = 64'h1000;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            req_valid3 = 1'b0;
            exp_en = (i == 1) || (i == 5) || (i == 9) || (i == 13);
            chk($sformatf("lat3_rd_en_%0d", i), 128'(mem_rd_en3), 128'(exp_en));
            if (exp_en)
                chk($sformatf("lat3_rd_addr_%0d", i), 128'(mem_rd_addr3),
                    128'(64'h1000 + 64'(4 * ((i - 1) / 4))));
            chk($sformatf("lat3_valid_%0d", i), 128'(resp_valid3), 128'(i == 17));
        end
        chk("lat3_resp_addr", 128'(resp_addr3), 128'(64'h1000));
        chk("lat3_resp_data", resp_data3, 128'hC0DE100C_C0DE1008_C0DE1004_C0DE1000);
        resp_ready3 = 1'b1;
        @(negedge clk);
        resp_ready3 = 1'b0;
        chk("lat3_idle_valid", 128'(resp_valid3), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for instruction-cache line refills. Accepts one line request at a time from the icache miss path over a valid/ready handshake.
- Fetches the four 32-bit words of the 16-byte line sequentially from a word-wide, fixed-latency instruction memory port. Assembles them into a 128-bit line and returns it over a valid/ready response channel.
- Sits between the icache and the instruction memory (SRAM or DPI-backed model).

Parameters:
- ADDR_W, 64, address width in bits.
- MEM_LAT, 1, cycles from mem_rd_en sample to mem_rd_data valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  in  1  icache presents a refill request.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  miss address; bits [3:0] ignored.
- resp_valid  out  1  assembled line is valid.
- resp_ready  in  1  icache accepts the line.
- resp_addr  out  ADDR_W  line-aligned address of the returned line.
- resp_data  out  128  line data; word k (address line_addr+4k) in bits [32k+31:32k].
- mem_rd_en  out  1  one-cycle read strobe to the instruction memory.
- mem_rd_addr  out  ADDR_W  word address of the read; always 4-byte aligned.
- mem_rd_data  in  32  read data, valid exactly MEM_LAT cycles after the mem_rd_en cycle.

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; mem_rd_en=0; resp_addr=0; resp_data=0; mem_rd_addr=0; word_idx=0; lat_cnt=0.
- States: IDLE, READ, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). The handshake fires when req_valid && req_ready at a posedge.
- On handshake:
  - line_addr <= {req_addr[ADDR_W-1:4], 4'b0}.
  - word_idx <= 0.
  - state <= READ.
- READ (always exactly 1 cycle):
  - mem_rd_en=1; mem_rd_addr=line_addr + 4*word_idx.
  - lat_cnt <= MEM_LAT; state <= WAIT.
- WAIT (always exactly MEM_LAT cycles):
  - mem_rd_en=0.
  - If lat_cnt==1, capture mem_rd_data into resp_data[32*word_idx +: 32]. Then, if word_idx==3, state <= RESP; otherwise word_idx++ and state <= READ.
  - Otherwise lat_cnt--.
- RESP:
  - resp_valid=1; resp_addr=line_addr. resp_data/resp_addr stay stable while resp_valid && !resp_ready.
  - On resp_ready: with req_valid set, accept the new request and go directly to READ (back-to-back); without it, go to IDLE.
- Latency: resp_valid rises exactly 4*(MEM_LAT+1) cycles after the request handshake edge. With MEM_LAT=1 that is 8 cycles.
- Only one outstanding memory read at any time. mem_rd_en is never high in two consecutive cycles.
- Word order is strictly 0,1,2,3; there is no critical-word-first.
- req_addr is sampled only at handshake; later changes have no effect.
- resp_ready while resp_valid=0 is ignored.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. Any in-flight read data is discarded; no partial line is ever presented.
- Line address arithmetic wraps modulo 2^ADDR_W; no carry past bit ADDR_W-1.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, READ, WAIT, RESP}.
  - LINE_BYTES=16, WORDS_PER_LINE=4, OFFSET_W=4, WORD_BYTES=4.
  - line data typedef (128-bit).
- These constants are shared with the icache so both ends agree on line geometry.
- No sub-module: the FSM, word index and latency counter live in one module.

Test Plan:
- Basic refill, MEM_LAT=1, memory returns {16'hC0DE, addr[15:0]}. req_addr=0x0000_0000_8000_0004 → mem_rd_addr sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C. resp_valid at handshake+8, resp_addr=0x80000000, resp_data=0xC0DE000C_C0DE0008_C0DE0004_C0DE0000.
- MEM_LAT=3, req_addr=0x1000 → mem_rd_en pulses at handshake+1, +5, +9, +13. resp_valid at handshake+16.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_data/resp_addr unchanged, req_ready=0, no mem_rd_en. Release → line accepted, back to IDLE.
- Back-to-back: in RESP drive resp_ready=1 and req_valid=1 with req_addr=0x2010 → next cycle state READ, mem_rd_addr=0x2010, no idle bubble. Second resp_addr=0x2010.
- Reset mid-refill: assert rst during WAIT of word 2 → next cycle req_ready=1, resp_valid=0, mem_rd_en=0. A subsequent request to 0x3000 returns a complete, correct line.
- Address wrap: req_addr=0xFFFF_FFFF_FFFF_FFFC → line_addr 0xFFFF_FFFF_FFFF_FFF0, last read 0xFFFF_FFFF_FFFF_FFFC, no wrap to 0.
